mc_control_fsm: RTL and testbench

Multi-cycle main control unit for the virus-detection MIPS-style processor. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath enables and the 2-bit `aluop` code consumed by the ALU function decoder, so it is the issuing end of the `aluop`/`funct` interface. It also stalls the execute state for the multi-cycle custom `muladdmod` R-type operation.

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_control_fsm_if.sv | 36 +++
 rtl/mc_stall_counter.sv | 24 ++
 rtl/mc_control_fsm.sv | 108 ++++++++++
 tb/tb_mc_control_fsm.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle main control unit:
// state encoding, opcodes, aluop codes and the per-state control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_ADDI  = 2'd3;

    localparam logic [3:0] FUNCT_MULADDMOD = 4'h8;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic [1:0] pcsource;
        logic       retire;
    } ctrl_t;

    // Control word that must be visible while the FSM sits in state s.
    function automatic ctrl_t ctrl_for_state(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1; c.irwrite = 1'b1; c.pcwrite = 1'b1;
                c.alusrcb = 2'd1; c.aluop = ALUOP_ADD;
            end
            S_DECODE:  begin c.alusrcb = 2'd3; c.aluop = ALUOP_ADD; end
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; c.aluop = ALUOP_ADD; end
            S_MEMRD:   begin c.memread = 1'b1; c.iord = 1'b1; end
            S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.retire = 1'b1; end
            S_MEMWR:   begin c.memwrite = 1'b1; c.iord = 1'b1; c.retire = 1'b1; end
            S_EXEC:    begin c.alusrca = 1'b1; c.alusrcb = 2'd0; c.aluop = ALUOP_FUNCT; end
            S_RWB:     begin c.regwrite = 1'b1; c.regdst = 1'b1; c.retire = 1'b1; end
            S_BRANCH: begin
                c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcwritecond = 1'b1;
                c.pcsource = 2'd1; c.retire = 1'b1;
            end
            S_JUMP:    begin c.pcwrite = 1'b1; c.pcsource = 2'd2; c.retire = 1'b1; end
            S_ADDI_EX: begin c.alusrca = 1'b1; c.alusrcb = 2'd2; c.aluop = ALUOP_ADDI; end
            S_ADDI_WB: begin c.regwrite = 1'b1; c.retire = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction-field inputs and datapath-control outputs of the main control unit.
// master = control FSM, slave = datapath.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       retire;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct,
        output aluop, alusrca, alusrcb, pcwrite, pcwritecond, iord, memread,
               memwrite, memtoreg, irwrite, regdst, regwrite, pcsource,
               retire, illegal_op, state
    );

    modport slave (
        output opcode, funct,
        input  aluop, alusrca, alusrcb, pcwrite, pcwritecond, iord, memread,
               memwrite, memtoreg, irwrite, regdst, regwrite, pcsource,
               retire, illegal_op, state
    );
endinterface

// File: rtl/mc_stall_counter.sv
// Saturating 4-bit EXEC-cycle counter; o_done once the count reaches LAST.
module mc_stall_counter #(
    parameter logic [3:0] LAST = 4'd2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_done
);
    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (i_en && (r_count != 4'hF)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_done = (r_count >= LAST);
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM with registered outputs decoded from next state.
// Build option MC_CTRL_MULADD_STALL_EN holds EXEC for MULADD_CYCLES on muladdmod.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MULADD_CYCLES = 3
) (
    input logic               clk,
    input logic               rst_n,
    mc_control_fsm_if.master  bus
);
    if ((MULADD_CYCLES < 2) || (MULADD_CYCLES > 15)) begin : g_bad_muladd_cycles
        $error("MULADD_CYCLES must be in 2..15");
    end

    state_e r_state;
    state_e w_next;
    ctrl_t  r_ctrl;
    logic   r_illegal;
    logic   w_illegal;
    logic   w_exec_done;

`ifdef MC_CTRL_MULADD_STALL_EN
    logic w_is_muladd;
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_cnt_done;

    assign w_is_muladd = (bus.funct[3:0] == FUNCT_MULADDMOD);
    assign w_cnt_clear = (w_next == S_EXEC) && (r_state != S_EXEC);
    assign w_cnt_en    = (r_state == S_EXEC);

    mc_stall_counter #(
        .LAST (4'(MULADD_CYCLES - 1))
    ) u_stall (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_done  (w_cnt_done)
    );

    assign w_exec_done = !w_is_muladd || w_cnt_done;
`else
    assign w_exec_done = 1'b1;
`endif

    // NOTE: state and output registers use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_START;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= ctrl_for_state(w_next);
            r_illegal <= w_illegal;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_START:  w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:         w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXEC:    w_next = w_exec_done ? S_RWB : S_EXEC;
            S_ADDI_EX: w_next = S_ADDI_WB;
            S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
            default:   w_next = S_START;
        endcase
    end

    assign bus.aluop       = r_ctrl.aluop;
    assign bus.alusrca     = r_ctrl.alusrca;
    assign bus.alusrcb     = r_ctrl.alusrcb;
    assign bus.pcwrite     = r_ctrl.pcwrite;
    assign bus.pcwritecond = r_ctrl.pcwritecond;
    assign bus.iord        = r_ctrl.iord;
    assign bus.memread     = r_ctrl.memread;
    assign bus.memwrite    = r_ctrl.memwrite;
    assign bus.memtoreg    = r_ctrl.memtoreg;
    assign bus.irwrite     = r_ctrl.irwrite;
    assign bus.regdst      = r_ctrl.regdst;
    assign bus.regwrite    = r_ctrl.regwrite;
    assign bus.pcsource    = r_ctrl.pcsource;
    assign bus.retire      = r_ctrl.retire;
    assign bus.illegal_op  = r_illegal;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues the expected per-cycle
// state/control vector, a negedge monitor pops and compares.
module tb_mc_control_fsm;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic pend_illegal;
    logic [21:0] sb_q[$];

    mc_control_fsm_if bus_if();

    mc_control_fsm #(
        .MULADD_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected {state, aluop, alusrca, alusrcb, pcwrite, pcwritecond, iord, memread,
    // memwrite, memtoreg, irwrite, regdst, regwrite, pcsource, retire, illegal_op}.
    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic ill);
        logic [1:0] aop, srcb, psrc;
        logic srca, pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, ret;
        {aop, srcb, psrc} = '0;
        {srca, pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, ret} = '0;
        case (st)
            4'd1:  begin mr = 1; irw = 1; pcw = 1; srcb = 2'd1; end
            4'd2:  srcb = 2'd3;
            4'd3:  begin srca = 1; srcb = 2'd2; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; ret = 1; end
            4'd6:  begin mw = 1; iord = 1; ret = 1; end
            4'd7:  begin srca = 1; aop = 2'd2; end
            4'd8:  begin rw = 1; rdst = 1; ret = 1; end
            4'd9:  begin srca = 1; aop = 2'd1; pcwc = 1; psrc = 2'd1; ret = 1; end
            4'd10: begin pcw = 1; psrc = 2'd2; ret = 1; end
            4'd11: begin srca = 1; srcb = 2'd2; aop = 2'd3; end
            4'd12: begin rw = 1; ret = 1; end
            default: ;
        endcase
        return {st, aop, srca, srcb, pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, psrc, ret, ill};
    endfunction

    function automatic logic [21:0] sample();
        return {bus_if.state, bus_if.aluop, bus_if.alusrca, bus_if.alusrcb, bus_if.pcwrite,
                bus_if.pcwritecond, bus_if.iord, bus_if.memread, bus_if.memwrite,
                bus_if.memtoreg, bus_if.irwrite, bus_if.regdst, bus_if.regwrite,
                bus_if.pcsource, bus_if.retire, bus_if.illegal_op};
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            logic [21:0] e;
            e = sb_q.pop_front();
            check($sformatf("cycle_st%0d", e[21:18]), 32'(sample()), 32'(e));
        end
    end

    // Called just after the edge that enters FETCH; queues the whole instruction.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int stop_after);
        logic [3:0] seq[$];
        int n_exec;
        logic ill;
        seq = {4'd1, 4'd2};
        ill = 1'b0;
        case (op)
            6'h23: begin seq.push_back(4'd3); seq.push_back(4'd4); seq.push_back(4'd5); end
            6'h2B: begin seq.push_back(4'd3); seq.push_back(4'd6); end
            6'h04: seq.push_back(4'd9);
            6'h02: seq.push_back(4'd10);
            6'h08: begin seq.push_back(4'd11); seq.push_back(4'd12); end
            6'h00: begin
                n_exec = 1;
`ifdef MC_CTRL_MULADD_STALL_EN
                if (fn[3:0] == 4'h8) n_exec = 3;
`endif
                for (int i = 0; i < n_exec; i++) seq.push_back(4'd7);
                seq.push_back(4'd8);
            end
            default: ill = 1'b1;
        endcase
        if (stop_after > 0) while (seq.size() > stop_after) void'(seq.pop_back());
        bus_if.opcode = op;
        bus_if.funct  = fn;
        for (int i = 0; i < seq.size(); i++) sb_q.push_back(exp_vec(seq[i], (i == 0) && pend_illegal));
        pend_illegal = ill;
        repeat (seq.size() - 1) @(posedge clk);
        if (stop_after == 0) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        pend_illegal = 1'b0;
        rst_n = 1'b0;
        bus_if.opcode = 6'h00;
        bus_if.funct = 6'h00;
        sb_q.push_back(exp_vec(4'd0, 1'b0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(6'h23, 6'h00, 0);   // lw
        issue(6'h00, 6'h20, 0);   // add
        issue(6'h00, 6'h08, 0);   // muladdmod
        issue(6'h2B, 6'h00, 0);   // sw
        issue(6'h04, 6'h00, 0);   // beq
        issue(6'h02, 6'h00, 0);   // j
        issue(6'h08, 6'h00, 0);   // addi
        issue(6'h3F, 6'h00, 0);   // illegal
        issue(6'h23, 6'h00, 0);   // lw, FETCH carries illegal_op pulse

        // sw interrupted by reset while in MEMWR
        issue(6'h2B, 6'h00, 4);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_memwrite", 32'(bus_if.memwrite), 32'd0);
        check("async_rst_state", 32'(bus_if.state), 32'd0);
        check("async_rst_retire", 32'(bus_if.retire), 32'd0);
        pend_illegal = 1'b0;
        sb_q.push_back(exp_vec(4'd0, 1'b0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(6'h08, 6'h00, 0);   // addi after reset
        issue(6'h00, 6'h22, 0);   // sub

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
